// File: rtl/axis_spi_dac_tx_if.sv
// AXI-Stream sample channel feeding the SPI DAC serializer.
interface axis_if #(
    parameter int unsigned DATA_W = 16
) ();
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_spi_dac_tx.sv
// AXI-Stream slave to SPI mode-0 DAC serializer, MSB first, cs_n framed.
// A one-word holding buffer accepts the next sample while the current frame shifts.
module axis_spi_dac_tx #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned CLK_DIV  = 10,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned CS_GAP   = 4
) (
    input  logic clk,
    input  logic resetn,
    axis_if.slave s_axis,
    output logic cs_n,
    output logic sclk,
    output logic mosi,
    output logic busy,
    output logic frame_done
);

    localparam int unsigned MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int unsigned MAX_B   = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
    localparam int unsigned MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAX_CNT = (MAX_C > DATA_W) ? MAX_C : DATA_W;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
    localparam int unsigned BIT_W   = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic [DATA_W-1:0] shift_reg, shift_nxt;
    logic [DATA_W-1:0] buf_data, buf_data_nxt;
    logic              buf_full, buf_full_nxt;
    logic              tready, tready_nxt;
    logic              cs_n_nxt, sclk_nxt, mosi_nxt, busy_nxt, frame_done_nxt;
    logic              accept_c;

    assign s_axis.tready = tready;
    assign accept_c      = s_axis.tvalid && tready;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            buf_data   <= '0;
            buf_full   <= 1'b0;
            tready     <= 1'b0;
            cs_n       <= 1'b1;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shift_reg  <= shift_nxt;
            buf_data   <= buf_data_nxt;
            buf_full   <= buf_full_nxt;
            tready     <= tready_nxt;
            cs_n       <= cs_n_nxt;
            sclk       <= sclk_nxt;
            mosi       <= mosi_nxt;
            busy       <= busy_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    // Next state, buffer and serial line control
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        bit_cnt_nxt    = bit_cnt;
        shift_nxt      = shift_reg;
        buf_data_nxt   = buf_data;
        buf_full_nxt   = buf_full;
        cs_n_nxt       = cs_n;
        sclk_nxt       = sclk;
        mosi_nxt       = mosi;
        busy_nxt       = busy;
        frame_done_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (buf_full) begin
                    // shift_reg holds the bits still to come, pre-aligned so the next bit is the MSB
                    shift_nxt    = {buf_data[DATA_W-2:0], 1'b0};
                    mosi_nxt     = buf_data[DATA_W-1];
                    buf_full_nxt = 1'b0;
                    cs_n_nxt     = 1'b0;
                    busy_nxt     = 1'b1;
                    cnt_nxt      = '0;
                    bit_cnt_nxt  = '0;
                    state_nxt    = SETUP;
                end
            end
            SETUP: begin
                if (cnt == CNT_W'(CS_SETUP - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            SHIFT: begin
                if (cnt == CNT_W'(CLK_DIV - 1)) begin
                    cnt_nxt  = '0;
                    sclk_nxt = !sclk;
                    if (sclk) begin
                        if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                            state_nxt = HOLD;
                        end else begin
                            bit_cnt_nxt = bit_cnt + BIT_W'(1);
                            mosi_nxt    = shift_reg[DATA_W-1];
                            shift_nxt   = {shift_reg[DATA_W-2:0], 1'b0};
                        end
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt == CNT_W'(CS_HOLD - 1)) begin
                    cnt_nxt        = '0;
                    cs_n_nxt       = 1'b1;
                    frame_done_nxt = 1'b1;
                    if (CS_GAP == 0) begin
                        busy_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = GAP;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == CNT_W'(CS_GAP - 1)) begin
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Accept only lands while the buffer is empty, so it never collides with a load
        if (accept_c) begin
            buf_full_nxt = 1'b1;
            buf_data_nxt = s_axis.tdata;
        end
        tready_nxt = !buf_full_nxt;
    end

endmodule
